// File: rtl/neuron_pkg.sv
// Shared Q3.12 constants and encoder state type for the neuron core blocks.
package neuron_pkg;
  localparam int INT_W = 3;
  localparam int FRC_W = 12;
  localparam int W     = 1 + INT_W + FRC_W;

  localparam logic signed [W-1:0] V_TH_HALF = 16'sh0800;
  localparam logic signed [W-1:0] V_ZERO    = 16'sh0000;

  typedef enum logic [1:0] {HYST, ARMED, REFRAC} enc_state_t;
endpackage

// File: rtl/spike_event_fifo.sv
// Event queue: registered storage, pointers with an extra wrap bit, registered count.
module spike_event_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot the push lands in.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/spike_event_encoder.sv
// Threshold-crossing spike detector with refractory/hysteresis gating and a timestamped event queue.
// Optional saturating spike counter enabled by defining SPIKE_COUNT_EN.
module spike_event_encoder
  import neuron_pkg::*;
#(
  parameter int                    W      = 16,
  parameter int                    TS_W   = 16,
  parameter int                    DEPTH  = 8,
  parameter logic signed [W-1:0]   V_TH   = V_TH_HALF,
  parameter logic signed [W-1:0]   V_LO   = V_ZERO,
  parameter int                    REFRAC = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     v_valid,
  input  logic signed [W-1:0]      v,
  input  logic                     clr,
  output logic                     ev_valid,
  input  logic                     ev_ready,
  output logic [TS_W-1:0]          ev_ts,
  output logic [W-1:0]             ev_v,
  output logic                     ev_overflow,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [15:0]              spike_count
);
  localparam int RC_W = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;

  enc_state_t        state, state_nx;
  logic [RC_W-1:0]   rcnt, rcnt_nx;
  logic [TS_W-1:0]   ts;
  logic              fire, pop, full, empty, drop;
  logic [TS_W+W-1:0] head;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= HYST;
      rcnt  <= '0;
      ts    <= '0;
    end else begin
      state <= state_nx;
      rcnt  <= rcnt_nx;
      if (v_valid) ts <= ts + 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    rcnt_nx  = rcnt;
    fire     = 1'b0;
    if (v_valid) begin
      unique case (state)
        HYST:  if (v <= V_LO) state_nx = ARMED;
        ARMED: if (v >= V_TH) begin
          fire = 1'b1;
          if (REFRAC == 0) state_nx = HYST;
          else begin
            state_nx = neuron_pkg::REFRAC;
            rcnt_nx  = RC_W'(REFRAC);
          end
        end
        neuron_pkg::REFRAC: begin
          rcnt_nx = rcnt - 1'b1;
          if (rcnt == RC_W'(1)) state_nx = HYST;
        end
        default: state_nx = HYST;
      endcase
    end
  end

  assign pop  = ev_valid && ev_ready;
  assign drop = fire && full && !pop;

  spike_event_fifo #(.WIDTH(TS_W + W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fire),
    .pop   (pop),
    .din   ({ts, v}),
    .dout  (head),
    .count (fifo_count),
    .full  (full),
    .empty (empty)
  );

  // Storage is not reset, so the head is masked to zero while the queue is empty.
  assign ev_valid = !empty;
  assign ev_ts    = empty ? '0 : head[TS_W+W-1:W];
  assign ev_v     = empty ? '0 : head[W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       ev_overflow <= 1'b0;
    else if (drop) ev_overflow <= 1'b1;
    else if (clr)  ev_overflow <= 1'b0;
  end

`ifdef SPIKE_COUNT_EN
  logic [15:0] sc;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         sc <= '0;
    else if (clr)                    sc <= '0;
    else if (fire && sc != 16'hFFFF) sc <= sc + 1'b1;
  end
  assign spike_count = sc;
`else
  assign spike_count = '0;
`endif
endmodule

// File: tb/tb_spike_event_encoder.sv
// Scenario bench for spike_event_encoder with an event-level reference queue model.
module tb_spike_event_encoder;
  localparam int TS_W = 4;
  localparam int DEPTH = 8;
  localparam int REFRAC = 8;
`ifdef SPIKE_COUNT_EN
  localparam bit SC_EN = 1'b1;
`else
  localparam bit SC_EN = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b0, v_valid = 1'b0, clr = 1'b0, ev_ready = 1'b0;
  logic [15:0] v = '0;
  logic ev_valid, ev_overflow;
  logic [TS_W-1:0] ev_ts;
  logic [15:0] ev_v, spike_count;
  logic [$clog2(DEPTH):0] fifo_count;

  int n_checks = 0, n_err = 0;

  // reference: queue of {ts,v}, armed flag, samples still to skip
  logic [TS_W+15:0] mq[$];
  bit m_armed, m_ovf;
  int m_skip, m_ts, m_scnt;

  always #5 clk = ~clk;

  spike_event_encoder #(.TS_W(TS_W), .DEPTH(DEPTH), .REFRAC(REFRAC)) dut (
    .clk(clk), .rst(rst), .v_valid(v_valid), .v(v), .clr(clr),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_ts(ev_ts), .ev_v(ev_v),
    .ev_overflow(ev_overflow), .fifo_count(fifo_count), .spike_count(spike_count)
  );

  task automatic model_update(input logic vv, input logic [15:0] vd, input logic rdy, input logic cl);
    bit popd, fire, drop;
    popd = (mq.size() > 0) && rdy;
    fire = 1'b0;
    if (vv) begin
      if (m_skip > 0) m_skip--;
      else if (!m_armed) m_armed = ($signed(vd) <= 16'sh0000);
      else if ($signed(vd) >= 16'sh0800) begin
        fire = 1'b1; m_armed = 1'b0; m_skip = REFRAC;
      end
    end
    if (popd) void'(mq.pop_front());
    drop = fire && (mq.size() >= DEPTH);
    if (fire && !drop) mq.push_back({m_ts[TS_W-1:0], vd});
    if (drop) m_ovf = 1'b1; else if (cl) m_ovf = 1'b0;
    if (cl) m_scnt = 0; else if (fire && m_scnt < 65535) m_scnt++;
    if (vv) m_ts = (m_ts + 1) % (1 << TS_W);
  endtask

  task automatic step(input logic vv, input logic [15:0] vd, input logic rdy, input logic cl);
    v_valid = vv; v = vd; ev_ready = rdy; clr = cl;
    @(posedge clk);
    model_update(vv, vd, rdy, cl);
    #1;
  endtask

  task automatic spike(input logic [15:0] fv, input logic rdy_fire);
    step(1'b1, 16'hFF00, 1'b0, 1'b0);
    step(1'b1, fv, rdy_fire, 1'b0);
    repeat (REFRAC) step(1'b1, 16'h0000, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    v_valid = 1'b0; ev_ready = 1'b0; clr = 1'b0;
    rst = 1'b1;
    mq.delete(); m_armed = 1'b0; m_ovf = 1'b0; m_skip = 0; m_ts = 0; m_scnt = 0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (ev_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%0b exp=0", ev_valid); end
    n_checks++; if (fifo_count !== '0) begin n_err++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
    n_checks++; if (ev_overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf got=%0b exp=0", ev_overflow); end
    n_checks++; if (spike_count !== 16'h0) begin n_err++; $display("FAIL reset_spikes got=%0d exp=0", spike_count); end
    n_checks++; if (ev_ts !== '0 || ev_v !== 16'h0) begin n_err++; $display("FAIL reset_head got=%h/%h exp=0/0", ev_ts, ev_v); end
    step(1'b1, 16'hECE1, 1'b0, 1'b0);
    repeat (2) begin
      n_checks++; if (ev_valid !== 1'b0) begin n_err++; $display("FAIL reset_neg_sample got=%0b exp=0", ev_valid); end
      step(1'b0, 16'h0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_single();
    do_reset();
    step(1'b1, 16'h0000, 1'b1, 1'b0);
    step(1'b1, 16'h0400, 1'b1, 1'b0);
    n_checks++; if (ev_valid !== 1'b0) begin n_err++; $display("FAIL single_early got=%0b exp=0", ev_valid); end
    step(1'b1, 16'h0900, 1'b1, 1'b0);
    n_checks++; if (ev_valid !== 1'b1) begin n_err++; $display("FAIL single_valid got=%0b exp=1", ev_valid); end
    n_checks++; if (ev_ts !== 4'd2) begin n_err++; $display("FAIL single_ts got=%0d exp=2", ev_ts); end
    n_checks++; if (ev_v !== 16'h0900) begin n_err++; $display("FAIL single_v got=%h exp=0900", ev_v); end
  endtask

  task automatic test_refrac_hyst();
    for (int i = 0; i < 20; i++) begin
      step(1'b1, (i % 2) ? 16'h0900 : 16'h0700, 1'b1, 1'b0);
      n_checks++; if (ev_valid !== 1'b0) begin n_err++; $display("FAIL refrac_quiet i=%0d got=%0b exp=0", i, ev_valid); end
    end
    step(1'b1, 16'hFF00, 1'b1, 1'b0);
    step(1'b1, 16'h0900, 1'b0, 1'b0);
    n_checks++; if (ev_valid !== 1'b1) begin n_err++; $display("FAIL rearm_valid got=%0b exp=1", ev_valid); end
    n_checks++; if (ev_ts !== 4'(24)) begin n_err++; $display("FAIL rearm_ts got=%0d exp=%0d", ev_ts, 24 % 16); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int k = 0; k < 9; k++) spike(16'h0900 + 16'(k), 1'b0);
    n_checks++; if (fifo_count !== 4'd8) begin n_err++; $display("FAIL ovf_count got=%0d exp=8", fifo_count); end
    n_checks++; if (ev_overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag got=%0b exp=1", ev_overflow); end
    n_checks++; if (spike_count !== (SC_EN ? 16'd9 : 16'd0)) begin n_err++; $display("FAIL ovf_spikes got=%0d exp=%0d", spike_count, SC_EN ? 9 : 0); end
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if (ev_valid !== 1'b1 || ev_v !== 16'h0900 + 16'(k) || ev_ts !== 4'((10 * k + 1) % 16)) begin
        n_err++; $display("FAIL drain k=%0d got=%0b/%0d/%h exp=1/%0d/%h", k, ev_valid, ev_ts, ev_v, (10 * k + 1) % 16, 16'h0900 + 16'(k));
      end
      step(1'b0, 16'h0, 1'b1, 1'b0);
    end
    n_checks++; if (ev_valid !== 1'b0) begin n_err++; $display("FAIL ninth_absent got=%0b exp=0", ev_valid); end
    step(1'b0, 16'h0, 1'b0, 1'b1);
    n_checks++; if (ev_overflow !== 1'b0) begin n_err++; $display("FAIL clr_ovf got=%0b exp=0", ev_overflow); end
  endtask

  task automatic test_full_pop();
    for (int k = 0; k < 8; k++) spike(16'h0A00 + 16'(k), 1'b0);
    step(1'b1, 16'hFF00, 1'b0, 1'b0);
    step(1'b1, 16'h0B00, 1'b1, 1'b0);
    n_checks++; if (fifo_count !== 4'd8) begin n_err++; $display("FAIL fullpop_count got=%0d exp=8", fifo_count); end
    n_checks++; if (ev_overflow !== 1'b0) begin n_err++; $display("FAIL fullpop_ovf got=%0b exp=0", ev_overflow); end
    n_checks++; if (ev_v !== 16'h0A01) begin n_err++; $display("FAIL fullpop_head got=%h exp=0a01", ev_v); end
    n_checks++; if (spike_count !== (SC_EN ? 16'd9 : 16'd0)) begin n_err++; $display("FAIL fullpop_spikes got=%0d exp=%0d", spike_count, SC_EN ? 9 : 0); end
    repeat (7) step(1'b0, 16'h0, 1'b1, 1'b0);
    n_checks++; if (ev_valid !== 1'b1 || ev_v !== 16'h0B00) begin n_err++; $display("FAIL fullpop_last got=%0b/%h exp=1/0b00", ev_valid, ev_v); end
  endtask

  task automatic test_wrap_and_reset();
    do_reset();
    for (int i = 0; i < 17; i++) step(1'b1, 16'h0000, 1'b0, 1'b0);
    step(1'b1, 16'h0900, 1'b0, 1'b0);
    n_checks++; if (ev_valid !== 1'b1 || ev_ts !== 4'd1) begin n_err++; $display("FAIL wrap_ts got=%0b/%0d exp=1/1", ev_valid, ev_ts); end
    do_reset();
    spike(16'h0901, 1'b0);
    spike(16'h0902, 1'b0);
    step(1'b1, 16'hFF00, 1'b0, 1'b0);
    step(1'b1, 16'h0903, 1'b0, 1'b0);
    step(1'b1, 16'h0000, 1'b0, 1'b0);
    n_checks++; if (fifo_count !== 4'd3) begin n_err++; $display("FAIL midop_pre got=%0d exp=3", fifo_count); end
    do_reset();
    n_checks++; if (fifo_count !== '0 || ev_valid !== 1'b0) begin n_err++; $display("FAIL midop_flush got=%0d/%0b exp=0/0", fifo_count, ev_valid); end
    step(1'b1, 16'h0900, 1'b0, 1'b0);
    n_checks++; if (ev_valid !== 1'b0) begin n_err++; $display("FAIL midop_hyst got=%0b exp=0", ev_valid); end
    step(1'b1, 16'h0000, 1'b0, 1'b0);
    step(1'b1, 16'h0900, 1'b0, 1'b0);
    n_checks++; if (ev_valid !== 1'b1 || ev_ts !== 4'd2) begin n_err++; $display("FAIL midop_ts got=%0b/%0d exp=1/2", ev_valid, ev_ts); end
  endtask

  task automatic test_random();
    logic vv, rdy, cl;
    logic [15:0] vd;
    logic [TS_W+15:0] hd;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      vv  = ($urandom_range(0, 3) != 0);
      vd  = 16'($urandom_range(0, 16'h1800)) - 16'h0C00;
      rdy = ($urandom_range(0, 9) < 3);
      cl  = !vv && ($urandom_range(0, 15) == 0);
      step(vv, vd, rdy, cl);
      n_checks++;
      if (ev_valid !== (mq.size() > 0) || fifo_count !== ($clog2(DEPTH) + 1)'(mq.size())) begin
        n_err++; $display("FAIL rand_occ c=%0d got=%0b/%0d exp=%0d", c, ev_valid, fifo_count, mq.size());
      end
      if (mq.size() > 0) begin
        hd = mq[0];
        n_checks++;
        if ({ev_ts, ev_v} !== hd) begin n_err++; $display("FAIL rand_head c=%0d got=%0d/%h exp=%0d/%h", c, ev_ts, ev_v, hd[TS_W+15:16], hd[15:0]); end
      end
      n_checks++;
      if (ev_overflow !== m_ovf || spike_count !== (SC_EN ? 16'(m_scnt) : 16'd0)) begin
        n_err++; $display("FAIL rand_flags c=%0d got=%0b/%0d exp=%0b/%0d", c, ev_overflow, spike_count, m_ovf, SC_EN ? m_scnt : 0);
      end
    end
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_single();
    test_refrac_hyst();
    test_overflow();
    test_full_pop();
    test_wrap_and_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
